mem_stage_access_unit: RTL and testbench
========================================

Name: mem_stage_access_unit

Overview:
- Consumer end of the EX/MEM pipeline register in the 5-stage MIPS core. It takes the EX/MEM outputs, services loads and stores against an internal word-addressed data RAM with configurable access latency, and drives the MEM/WB-side outputs.
- Asserts `stall` back to the upstream pipeline while an access is in flight. Upstream registers (PC, IF/ID, ID/EX, EX/MEM) hold while `stall`=1.

Parameters:
- DEPTH, 256, number of 32-bit words in the data RAM (power of 2).
- LATENCY, 2, extra cycles per load/store (0..15); 0 means a single-cycle access with no stall.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read_in  in  1  load request from EX/MEM.
- mem_write_in  in  1  store request from EX/MEM.
- reg_write_in  in  1  writeback enable from EX/MEM.
- mem_to_reg_in  in  1  writeback mux select from EX/MEM.
- mux_reg_dst_out_in  in  5  destination register from EX/MEM.
- ALU_result_in  in  32  byte address for loads/stores, or the ALU result to pass through.
- mux_ALU_src_B_out_in  in  32  store data.
- stall  out  1  combinational; high while an access is pending.
- reg_write_out  out  1  registered writeback enable to MEM/WB.
- mem_to_reg_out  out  1  registered.
- mux_reg_dst_out_out  out  5  registered.
- ALU_result_out  out  32  registered.
- mem_read_data_out  out  32  registered load data.
- misalign_err  out  1  registered one-cycle pulse.

Behaviour:
- **Reset (rst_n=0, async):**
  - FSM goes to IDLE; counter = 0; all registered outputs = 0.
  - RAM contents are not reset.
  - Reset mid-access abandons the access; a pending store is not written.
- **Request:** req = mem_read_in | mem_write_in. If both are high, treat as a store; mem_read_data_out = 0.
- **Address:**
  - Word index = ALU_result_in[2 +: log2(DEPTH)]. Higher bits are ignored, so the index wraps modulo DEPTH.
  - Misaligned means ALU_result_in[1:0] != 0.
- **FSM states:** IDLE, BUSY.
- **IDLE, no req:**
  - stall = 0.
  - On the edge, all inputs pass to the outputs.
  - mem_read_data_out = 0; misalign_err = 0.
- **IDLE, req, misaligned:**
  - stall = 0; no RAM access.
  - On the edge, outputs pass through with mem_read_data_out = 0 and misalign_err = 1 for one cycle.
- **IDLE, req, aligned, LATENCY=0:**
  - stall = 0.
  - Store: RAM is written on this edge.
  - Load: mem_read_data_out takes RAM[index] (combinational read) on this edge.
  - Control outputs pass through.
- **IDLE, req, aligned, LATENCY>0:**
  - stall = 1 combinationally.
  - On the edge: capture address, store data and all control inputs; counter = LATENCY-1; go to BUSY.
  - reg_write_out = 0 on this edge (bubble); the other outputs hold.
- **BUSY, counter > 0:**
  - stall = 1; counter decrements.
  - reg_write_out = 0; the other outputs hold.
  - Input changes are ignored; captured values are used.
- **BUSY, counter = 0:**
  - stall = 0.
  - On the edge, perform the access with captured values: store writes RAM, load samples RAM[index].
  - Outputs load the captured control, captured ALU result, and the load data.
  - Go to IDLE. Upstream advances on this same edge.
- **Stall duration:** exactly LATENCY cycles per aligned load/store; 0 for non-memory and misaligned instructions.
- **Back-to-back accesses:** the next request is seen in IDLE on the cycle after completion; no extra gap cycles.
- **Store forwarding:** a load from the same address immediately after a store returns the new data, because the write completes before the load's access edge.

Decomposition:
- Package `mem_stage_pkg`:
  - state enum {IDLE, BUSY};
  - localparam IDX_W = $clog2(DEPTH);
  - counter width constant (4 bits).
- Sub-module `data_ram`: DEPTH x 32 array, synchronous write (we, widx, wdata), combinational read (ridx → rdata), no reset.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- LATENCY=2, store addr 0x10 data 0xDEADBEEF, reg_write_in=0 → stall high exactly 2 cycles then 0; RAM word 4 = 0xDEADBEEF; misalign_err stays 0.
- Then load addr 0x10, reg_write_in=1, mux_reg_dst_out_in=5'd8 → stall 2 cycles with reg_write_out=0 during the stall; next edge mem_read_data_out=0xDEADBEEF, reg_write_out=1, mux_reg_dst_out_out=8.
- Non-memory instruction (ALU_result_in=0x1234, reg_write_in=1) → stall=0; outputs pass on the next edge with mem_read_data_out=0.
- Load addr 0x13 → no stall, misalign_err=1 for exactly one cycle, mem_read_data_out=0.
- Store addr 0x400 (DEPTH=256) data 0xA5A5A5A5, then load addr 0x0 → reads 0xA5A5A5A5 (index wrap).
- Deassert rst_n during BUSY of a store to 0x20 data 0x1 → outputs 0, stall 0, FSM IDLE; a later load of 0x20 does not return 0x1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage access unit and its data RAM.
package mem_stage_pkg;

    localparam int unsigned DEF_DEPTH = 256;
    localparam int unsigned IDX_W     = $clog2(DEF_DEPTH);
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_access_unit_data_ram.sv
// Word-addressed data RAM: synchronous write, combinational read, contents not reset.
module data_ram
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = IDX_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM stage: services loads/stores against the data RAM with a fixed extra latency,
// stalling upstream while an access is in flight, and registers the MEM/WB outputs.
module mem_stage_access_unit
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [REG_W-1:0]  mux_reg_dst_out_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] mux_ALU_src_B_out_in,
    output logic              stall,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [REG_W-1:0]  mux_reg_dst_out_out,
    output logic [DATA_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] mem_read_data_out,
    output logic              misalign_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cap_rd_q, cap_rd_d;
    logic               cap_wr_q, cap_wr_d;
    logic               cap_rw_q, cap_rw_d;
    logic               cap_m2r_q, cap_m2r_d;
    logic [REG_W-1:0]   cap_dst_q, cap_dst_d;
    logic [DATA_W-1:0]  cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0]  cap_wdata_q, cap_wdata_d;

    logic               reg_write_q, reg_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic [REG_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               misalign_q, misalign_d;

    logic               req;
    logic               misal;
    logic [AW-1:0]      in_idx;
    logic [AW-1:0]      cap_idx;

    logic               ram_we;
    logic [AW-1:0]      ram_widx;
    logic [AW-1:0]      ram_ridx;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    assign req     = mem_read_in | mem_write_in;
    assign misal   = (ALU_result_in[1:0] != 2'b00);
    assign in_idx  = ALU_result_in[2 +: AW];
    assign cap_idx = cap_addr_q[2 +: AW];

    data_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .widx  (ram_widx),
        .wdata (ram_wdata),
        .ridx  (ram_ridx),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_rd_d     = cap_rd_q;
        cap_wr_d     = cap_wr_q;
        cap_rw_d     = cap_rw_q;
        cap_m2r_d    = cap_m2r_q;
        cap_dst_d    = cap_dst_q;
        cap_addr_d   = cap_addr_q;
        cap_wdata_d  = cap_wdata_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        dst_d        = dst_q;
        alu_d        = alu_q;
        rdata_d      = rdata_q;
        misalign_d   = 1'b0;
        stall        = 1'b0;
        ram_we       = 1'b0;
        ram_widx     = in_idx;
        ram_ridx     = in_idx;
        ram_wdata    = mux_ALU_src_B_out_in;

        unique case (state_q)
            IDLE: begin
                if (!req || misal || (LATENCY == 0)) begin
                    // Single-cycle path: pass-through, misaligned reject, or zero-latency access
                    reg_write_d  = reg_write_in;
                    mem_to_reg_d = mem_to_reg_in;
                    dst_d        = mux_reg_dst_out_in;
                    alu_d        = ALU_result_in;
                    rdata_d      = '0;
                    misalign_d   = req & misal;
                    if (req && !misal) begin
                        ram_we = mem_write_in & rst_n;
                        if (mem_read_in && !mem_write_in) begin
                            rdata_d = ram_rdata;
                        end
                    end
                end else begin
                    stall       = 1'b1;
                    cap_rd_d    = mem_read_in;
                    cap_wr_d    = mem_write_in;
                    cap_rw_d    = reg_write_in;
                    cap_m2r_d   = mem_to_reg_in;
                    cap_dst_d   = mux_reg_dst_out_in;
                    cap_addr_d  = ALU_result_in;
                    cap_wdata_d = mux_ALU_src_B_out_in;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    reg_write_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                ram_widx  = cap_idx;
                ram_ridx  = cap_idx;
                ram_wdata = cap_wdata_q;
                if (cnt_q != '0) begin
                    stall       = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                    reg_write_d = 1'b0;
                end else begin
                    // Completion edge: access with captured values while upstream advances
                    ram_we       = cap_wr_q & rst_n;
                    reg_write_d  = cap_rw_q;
                    mem_to_reg_d = cap_m2r_q;
                    dst_d        = cap_dst_q;
                    alu_d        = cap_addr_q;
                    rdata_d      = (cap_rd_q && !cap_wr_q) ? ram_rdata : '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cap_rd_q     <= 1'b0;
            cap_wr_q     <= 1'b0;
            cap_rw_q     <= 1'b0;
            cap_m2r_q    <= 1'b0;
            cap_dst_q    <= '0;
            cap_addr_q   <= '0;
            cap_wdata_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            dst_q        <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_rd_q     <= cap_rd_d;
            cap_wr_q     <= cap_wr_d;
            cap_rw_q     <= cap_rw_d;
            cap_m2r_q    <= cap_m2r_d;
            cap_dst_q    <= cap_dst_d;
            cap_addr_q   <= cap_addr_d;
            cap_wdata_q  <= cap_wdata_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            dst_q        <= dst_d;
            alu_q        <= alu_d;
            rdata_q      <= rdata_d;
            misalign_q   <= misalign_d;
        end
    end

    assign reg_write_out       = reg_write_q;
    assign mem_to_reg_out      = mem_to_reg_q;
    assign mux_reg_dst_out_out = dst_q;
    assign ALU_result_out      = alu_q;
    assign mem_read_data_out   = rdata_q;
    assign misalign_err        = misalign_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed scenarios plus random instruction mix vs. a word-array model.
module tb_mem_stage_access_unit;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
    logic [4:0]  mux_reg_dst_out_in;
    logic [31:0] ALU_result_in, mux_ALU_src_B_out_in;
    logic        stall, reg_write_out, mem_to_reg_out, misalign_err;
    logic [4:0]  mux_reg_dst_out_out;
    logic [31:0] ALU_result_out, mem_read_data_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_known [DEPTH];
    int          known_list [$];

    mem_stage_access_unit #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mem_read_in          (mem_read_in),
        .mem_write_in         (mem_write_in),
        .reg_write_in         (reg_write_in),
        .mem_to_reg_in        (mem_to_reg_in),
        .mux_reg_dst_out_in   (mux_reg_dst_out_in),
        .ALU_result_in        (ALU_result_in),
        .mux_ALU_src_B_out_in (mux_ALU_src_B_out_in),
        .stall                (stall),
        .reg_write_out        (reg_write_out),
        .mem_to_reg_out       (mem_to_reg_out),
        .mux_reg_dst_out_out  (mux_reg_dst_out_out),
        .ALU_result_out       (ALU_result_out),
        .mem_read_data_out    (mem_read_data_out),
        .misalign_err         (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
        mux_reg_dst_out_in = '0; ALU_result_in = '0; mux_ALU_src_B_out_in = '0;
    endtask

    // One instruction from issue to retirement; called just after a rising edge.
    task automatic run(input string tag, input logic rd, input logic wr, input logic rw,
                       input logic m2r, input logic [4:0] dst, input logic [31:0] alu,
                       input logic [31:0] wd);
        int          n;
        int          idx;
        bit          aligned_mem;
        int          exp_stall;
        logic [31:0] exp_rdata;
        mem_read_in = rd; mem_write_in = wr; reg_write_in = rw; mem_to_reg_in = m2r;
        mux_reg_dst_out_in = dst; ALU_result_in = alu; mux_ALU_src_B_out_in = wd;
        idx         = int'((alu >> 2) % DEPTH);
        aligned_mem = (rd || wr) && (alu % 4 == 0);
        exp_stall   = aligned_mem ? int'(LATENCY) : 0;
        exp_rdata   = (aligned_mem && rd && !wr) ? model_mem[idx] : 32'h0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
            chk({tag, "_bubble"}, 32'(reg_write_out), 32'h0);
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
        if (aligned_mem && wr) begin
            model_mem[idx] = wd;
            if (!model_known[idx]) begin
                model_known[idx] = 1'b1;
                known_list.push_back(idx);
            end
        end
        chk({tag, "_rw"},    32'(reg_write_out),       32'(rw));
        chk({tag, "_m2r"},   32'(mem_to_reg_out),      32'(m2r));
        chk({tag, "_dst"},   32'(mux_reg_dst_out_out), 32'(dst));
        chk({tag, "_alu"},   ALU_result_out,           alu);
        chk({tag, "_rdata"}, mem_read_data_out,        exp_rdata);
        chk({tag, "_mis"},   32'(misalign_err),        32'((rd || wr) && (alu % 4 != 0)));
    endtask

    initial begin
        int kind;
        int k;
        logic [31:0] a;
        for (int i = 0; i < int'(DEPTH); i++) begin
            model_mem[i]   = 32'h0;
            model_known[i] = 1'b0;
        end
        rst_n = 1'b0;
        drive_idle();
        #12;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rw",    32'(reg_write_out), 32'h0);
        chk("rst_alu",   ALU_result_out, 32'h0);
        chk("rst_rdata", mem_read_data_out, 32'h0);
        chk("rst_mis",   32'(misalign_err), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run("st10",   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF);
        run("ld10",   1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h10, 32'h0);
        run("alu",    1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h1234, 32'h77);
        run("mis13",  1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h13, 32'h0);
        run("after",  1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h4, 32'h0);
        run("st400",  1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h400, 32'hA5A5A5A5);
        run("ld0",    1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0, 32'h0);
        run("both",   1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h8, 32'h12345678);
        run("ld8",    1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h8, 32'h0);
        run("st20",   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'h55);

        // Reset mid-access: the pending store of 0x1 must be dropped
        mem_read_in = 1'b0; mem_write_in = 1'b1; reg_write_in = 1'b1; mem_to_reg_in = 1'b0;
        mux_reg_dst_out_in = 5'd7; ALU_result_in = 32'h20; mux_ALU_src_B_out_in = 32'h1;
        #1;
        chk("rstmid_stall_pre", 32'(stall), 32'h1);
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall", 32'(stall), 32'h0);
        chk("rstmid_rw",    32'(reg_write_out), 32'h0);
        chk("rstmid_dst",   32'(mux_reg_dst_out_out), 32'h0);
        chk("rstmid_alu",   ALU_result_out, 32'h0);
        chk("rstmid_rdata", mem_read_data_out, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run("ld20", 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h20, 32'h0);

        // Random instruction mix; loads only target words the model has seen written
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            a    = $urandom;
            case (kind)
                0: run("r_alu", 1'b0, 1'b0, 1'($urandom), 1'($urandom), 5'($urandom), a, $urandom);
                1: run("r_st", 1'b0, 1'b1, 1'($urandom), 1'($urandom), 5'($urandom),
                       {a[31:2], 2'b00}, $urandom);
                2: begin
                    k = known_list[$urandom_range(0, known_list.size() - 1)];
                    a = {a[31:10], 8'(k), 2'b00};
                    run("r_ld", 1'b1, 1'b0, 1'($urandom), 1'($urandom), 5'($urandom), a, $urandom);
                end
                default: run("r_mis", 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 5'($urandom),
                             {a[31:2], 2'($urandom_range(1, 3))}, $urandom);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
